// File: rtl/weight_bram_loader.sv
// ============================================================================
// Module   : weight_bram_loader
// Purpose  : Unpacks a PACK-weight stream LSB-first onto the weight BRAM write port.
// Options  : WEIGHT_CKSUM_EN enables the running checksum of written weights.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_bram_loader #(
  parameter int ADDR  = 16,
  parameter int WIDE  = 4,
  parameter int DEPTH = 32768,
  parameter int PACK  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [ADDR-1:0]      i_base_addr,
  input  logic [ADDR:0]        i_length,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [PACK*WIDE-1:0] i_s_data,
  input  logic                 i_s_last,
  output logic                 o_wea,
  output logic [ADDR-1:0]      o_addra,
  output logic [WIDE-1:0]      o_dina,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [15:0]          o_cksum
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [ADDR-1:0] c_ADDR_MAX = ADDR'(DEPTH - 1);
  localparam logic [ADDR-1:0] c_ADDR_ONE = ADDR'(1);
  localparam logic [ADDR:0]   c_REM_ONE  = (ADDR + 1)'(1);
  localparam logic [ADDR:0]   c_REM_PACK = (ADDR + 1)'(PACK);
  localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   c_CNT_LOAD = CW'(PACK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR:0]        r_remaining;
  logic [PACK*WIDE-1:0] r_buf;
  logic [CW-1:0]        r_buf_cnt;
  logic                 r_last_short;
  logic [ADDR-1:0]      r_addr;
  logic                 r_wea;
  logic [ADDR-1:0]      r_addra;
  logic [WIDE-1:0]      r_dina;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_start_ok;
  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_fail;
  logic [WIDE-1:0]      w_weight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_buf_cnt counts weights still held back; the one already on dina is not
  // included, so a new word is taken exactly when the buffer runs dry.
  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_s_ready  = 1'b0;
    w_accept   = 1'b0;
    w_emit     = 1'b0;
    w_fail     = 1'b0;
    w_weight   = r_buf[WIDE-1:0];
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_ok = 1'b1;
          w_next     = (i_length == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (r_remaining == '0) begin
          w_next = S_DONE;
        end else if (r_last_short && (r_buf_cnt == '0)) begin
          w_next = S_DONE;
          w_fail = 1'b1;
        end else begin
          w_s_ready = (r_buf_cnt == '0) && !r_last_short;
          w_accept  = w_s_ready && i_s_valid;
          w_emit    = (r_buf_cnt != '0) || w_accept;
          if (r_buf_cnt == '0) begin
            w_weight = i_s_data[WIDE-1:0];
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_buf        <= '0;
      r_buf_cnt    <= '0;
      r_last_short <= 1'b0;
      r_addr       <= '0;
      r_wea        <= 1'b0;
      r_addra      <= '0;
      r_dina       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wea  <= w_emit;
      r_busy <= (w_next == S_STREAM);
      r_done <= (w_next == S_DONE);
      if (w_start_ok) begin
        r_remaining  <= i_length;
        r_addr       <= i_base_addr;
        r_buf_cnt    <= '0;
        r_last_short <= 1'b0;
        r_err        <= 1'b0;
      end
      if (w_fail) begin
        r_err <= 1'b1;
      end
      if (w_emit) begin
        r_addra     <= r_addr;
        r_dina      <= w_weight;
        r_addr      <= (r_addr == c_ADDR_MAX) ? '0 : r_addr + c_ADDR_ONE;
        r_remaining <= r_remaining - c_REM_ONE;
        if (r_buf_cnt != '0) begin
          r_buf     <= r_buf >> WIDE;
          r_buf_cnt <= r_buf_cnt - c_CNT_ONE;
        end else begin
          r_buf     <= i_s_data >> WIDE;
          r_buf_cnt <= c_CNT_LOAD;
        end
      end
      // A last word that cannot cover what is still owed ends the job with err.
      if (w_accept && i_s_last && (r_remaining > c_REM_PACK)) begin
        r_last_short <= 1'b1;
      end
    end
  end

`ifdef WEIGHT_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cksum <= '0;
    end else if (w_start_ok) begin
      r_cksum <= '0;
    end else if (r_wea) begin
      r_cksum <= r_cksum + 16'(r_dina);
    end
  end

  assign o_cksum = r_cksum;
`else
  assign o_cksum = '0;
`endif

  assign o_s_ready = w_s_ready;
  assign o_wea     = r_wea;
  assign o_addra   = r_addra;
  assign o_dina    = r_dina;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_weight_bram_loader.sv
// ============================================================================
// Module   : tb_weight_bram_loader
// Purpose  : Randomised self-checking bench for weight_bram_loader against a
//            word-level reference model of the expected BRAM write sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_weight_bram_loader;

  localparam int ADDR  = 16;
  localparam int WIDE  = 4;
  localparam int DEPTH = 32768;
  localparam int PACK  = 2;
  localparam int PW    = PACK * WIDE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR-1:0] base_addr = '0;
  logic [ADDR:0]   length = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [PW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic            wea;
  logic [ADDR-1:0] addra;
  logic [WIDE-1:0] dina;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     cksum;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];

  int drv_words[$];
  bit drv_lasts[$];
  int exp_addr[$];
  int exp_data[$];
  bit exp_err;
  int exp_nwords;

  weight_bram_loader #(
    .ADDR(ADDR), .WIDE(WIDE), .DEPTH(DEPTH), .PACK(PACK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_data(s_data), .i_s_last(s_last), .o_wea(wea), .o_addra(addra),
    .o_dina(dina), .o_busy(busy), .o_done(done), .o_err(err), .o_cksum(cksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wea) begin
      wr_addr.push_back(int'(addra));
      wr_data.push_back(int'(dina));
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  // Flattens the offered words into the weights the BRAM should receive.
  task automatic model_run(input int base, input int len);
    int owed;
    int addr;
    bit short_last;
    owed = len;
    addr = base;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    exp_nwords = 0;
    for (int j = 0; j < drv_words.size() && owed > 0; j++) begin
      short_last = drv_lasts[j] && (owed > PACK);
      exp_nwords++;
      for (int k = 0; k < PACK && owed > 0; k++) begin
        exp_addr.push_back(addr);
        exp_data.push_back((drv_words[j] >> (k * WIDE)) & ((1 << WIDE) - 1));
        addr = (addr + 1) % DEPTH;
        owed--;
      end
      if (short_last) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_monitor();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic run_xfer(input string name, input int base, input int len,
                          input int gap_pct);
    int  j;
    int  acc_first;
    int  start_cyc;
    bit  found;
    int  exp_ck;
    int  bubbles;
    model_run(base, len);
    exp_ck = 0;
`ifdef WEIGHT_CKSUM_EN
    foreach (exp_data[k]) exp_ck = (exp_ck + exp_data[k]) % 65536;
`endif
    @(posedge clk); #1;
    clear_monitor();
    start = 1'b1;
    base_addr = ADDR'(base);
    length = (ADDR + 1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    j = 0;
    acc_first = -1;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (j < drv_words.size() && $urandom_range(99) >= gap_pct) begin
        s_valid = 1'b1;
        s_data  = PW'(drv_words[j]);
        s_last  = drv_lasts[j];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = PW'($urandom);
      end
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (busy !== (len != 0) || done !== (len == 0) || err !== 1'b0) begin
          n_errors++;
          $display("FAIL %s start_resp: busy=%b done=%b err=%b, want busy=%b done=%b err=0",
                   name, busy, done, err, len != 0, len == 0);
        end
      end
      if (done) begin
        found = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || err !== exp_err || cksum !== 16'(exp_ck)) begin
          n_errors++;
          $display("FAIL %s at_done: busy=%b err=%b cksum=%0d, want busy=0 err=%b cksum=%0d",
                   name, busy, err, cksum, exp_err, exp_ck);
        end
        break;
      end
      if (s_valid && s_ready) begin
        if (j == 0) acc_first = cyc;
        j++;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL %s timeout: done never seen", name);
    end
    n_checks++;
    if (j !== exp_nwords) begin
      n_errors++;
      $display("FAIL %s words_accepted: got %0d, want %0d", name, j, exp_nwords);
    end
    n_checks++;
    if (wr_addr.size() !== exp_addr.size()) begin
      n_errors++;
      $display("FAIL %s write_count: got %0d, want %0d", name, wr_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[k]) begin
        n_checks++;
        if (wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
          n_errors++;
          $display("FAIL %s write[%0d]: addr=%0h data=%0h, want addr=%0h data=%0h",
                   name, k, wr_addr[k], wr_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    n_checks++;
    if (done_cyc.size() !== 1) begin
      n_errors++;
      $display("FAIL %s done_pulses: got %0d, want 1", name, done_cyc.size());
    end else if (wr_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc[0] !== wr_cyc[wr_cyc.size() - 1] + 1) begin
        n_errors++;
        $display("FAIL %s done_timing: done at %0d, last write at %0d",
                 name, done_cyc[0], wr_cyc[wr_cyc.size() - 1]);
      end
    end else begin
      n_checks++;
      if (done_cyc[0] !== start_cyc) begin
        n_errors++;
        $display("FAIL %s done_timing_len0: done at %0d, want %0d", name, done_cyc[0], start_cyc);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_errors++;
      $display("FAIL %s err_sticky: got %b, want %b", name, err, exp_err);
    end
    if (gap_pct == 0 && wr_cyc.size() > 0 && wr_cyc.size() == exp_addr.size()) begin
      bubbles = 0;
      foreach (wr_cyc[k]) if (wr_cyc[k] !== wr_cyc[0] + k) bubbles++;
      n_checks++;
      if (wr_cyc[0] !== acc_first + 1 || bubbles != 0) begin
        n_errors++;
        $display("FAIL %s write_timing: first write %0d (accept %0d), bubbles=%0d, want accept+1 and 0",
                 name, wr_cyc[0], acc_first, bubbles);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = PW'(8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_ready, wea, addra, dina, busy, done, err, cksum} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: rdy=%b wea=%b addra=%0h dina=%0h busy=%b done=%b err=%b ck=%0h, want all 0",
               s_ready, wea, addra, dina, busy, done, err, cksum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_monitor();
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: writes=%0d rdy=%b busy=%b, want 0 0 0", wr_addr.size(), s_ready, busy);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    drv_words = '{32'h21, 32'h43, 32'h65};
    drv_lasts = '{1'b0, 1'b0, 1'b1};
    run_xfer("basic", 16'h0010, 6, 0);
  endtask

  task automatic test_wrap();
    drv_words = '{int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255))};
    drv_lasts = '{1'b0, 1'b0, 1'b0};
    run_xfer("wrap", DEPTH - 2, 4, 0);
  endtask

  task automatic test_discard();
    drv_words = '{32'hBA, 32'hDC, 32'hFE};
    drv_lasts = '{1'b0, 1'b0, 1'b0};
    run_xfer("discard", 16'h0200, 3, 0);
  endtask

  task automatic test_short_last();
    drv_words = '{32'h21, 32'h43, 32'h65};
    drv_lasts = '{1'b0, 1'b1, 1'b0};
    run_xfer("short_last", 16'h0300, 6, 0);
  endtask

  task automatic test_len_zero();
    drv_words = '{32'h77};
    drv_lasts = '{1'b1};
    run_xfer("len_zero", 16'h0040, 0, 0);
  endtask

  task automatic test_reset_midstream();
    int j;
    drv_words = '{32'h21, 32'h43, 32'h65, 32'h87};
    drv_lasts = '{1'b0, 1'b0, 1'b0, 1'b1};
    model_run(16'h0100, 8);
    @(posedge clk); #1;
    clear_monitor();
    start = 1'b1;
    base_addr = 16'h0100;
    length = 17'd8;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = (c % 4 == 0);
      s_data = PW'(drv_words[j]);
      s_last = drv_lasts[j];
      @(negedge clk);
      if (s_valid && s_ready) j++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_checks++;
    if (wr_addr.size() !== 3) begin
      n_errors++;
      $display("FAIL stall_writes: got %0d writes, want 3", wr_addr.size());
    end else begin
      n_checks++;
      if (wr_cyc[2] !== wr_cyc[1] + 3) begin
        n_errors++;
        $display("FAIL stall_gap: write cycles %0d,%0d, want gap 3", wr_cyc[1], wr_cyc[2]);
      end
      foreach (wr_addr[k]) begin
        n_checks++;
        if (wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
          n_errors++;
          $display("FAIL stall_write[%0d]: addr=%0h data=%0h, want addr=%0h data=%0h",
                   k, wr_addr[k], wr_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, wea, addra, dina, busy, done, err, cksum} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: rdy=%b wea=%b addra=%0h dina=%0h busy=%b done=%b err=%b ck=%0h, want all 0",
               s_ready, wea, addra, dina, busy, done, err, cksum);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 3 || busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle: writes=%0d busy=%b rdy=%b done=%b, want 3 0 0 0",
               wr_addr.size(), busy, s_ready, done);
    end
    drv_words = '{32'hA9, 32'hCB};
    drv_lasts = '{1'b0, 1'b1};
    run_xfer("post_reset", 16'h0500, 4, 0);
  endtask

  task automatic test_random();
    int len;
    int base;
    int needed;
    int bad;
    string nm;
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(12);
      base = ($urandom_range(1) == 1) ? DEPTH - 1 - $urandom_range(5) : $urandom_range(DEPTH - 1);
      needed = (len + PACK - 1) / PACK;
      drv_words.delete();
      drv_lasts.delete();
      for (int w = 0; w <= needed; w++) begin
        drv_words.push_back($urandom_range((1 << PW) - 1));
        drv_lasts.push_back(1'b0);
      end
      if (needed > 1 && $urandom_range(3) == 0) begin
        bad = $urandom_range(needed - 2);
        drv_lasts[bad] = 1'b1;
      end else if (needed > 0 && $urandom_range(1) == 0) begin
        drv_lasts[needed - 1] = 1'b1;
      end
      nm = $sformatf("rand%0d", it);
      run_xfer(nm, base, len, (it % 3 == 0) ? 0 : $urandom_range(60));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_discard();
    test_short_last();
    test_len_zero();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
